matrix_mult_core: RTL and testbench

Sequential matrix-multiply engine that computes C = A × B for square N×N unsigned matrices. It reads A and B from two synchronous-read memories and writes each C element to a result memory. It also produces the 24-bit running sum of all C elements and a 24-bit busy-cycle count. These two outputs are what the board-level display path selects between (via SW[1]) and shows on HEX0–HEX5.

---
 rtl/matrix_mult_core_if.sv | 44 ++++
 rtl/matrix_mult_core.sv | 191 +++++++++++++++++++
 tb/tb_matrix_mult_core.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/matrix_mult_core_if.sv
// -----------------------------------------------------------------------------
// matrix_mult_core_if
// Bundles the control handshake and the three memory ports of the matrix
// multiply engine.
//   start              : request a multiply (environment -> core)
//   busy / done        : run status (core -> environment)
//   a_addr / a_rdata   : A memory port, data returned one cycle after address
//   b_addr / b_rdata   : B memory port, data returned one cycle after address
//   c_we/c_addr/c_wdata: C result write port
//   cycle_count        : busy cycles of the current or last run
//   result_sum         : modulo-2^24 sum of all C elements written
// Modports: slave = the core, master = the environment driving it.
// -----------------------------------------------------------------------------
interface matrix_mult_core_if #(
  parameter int N  = 4,
  parameter int DW = 8,
  parameter int CW = 2*DW + $clog2(N),
  parameter int AW = $clog2(N*N)
);
  logic          start;
  logic          busy;
  logic          done;
  logic [AW-1:0] a_addr;
  logic [DW-1:0] a_rdata;
  logic [AW-1:0] b_addr;
  logic [DW-1:0] b_rdata;
  logic          c_we;
  logic [AW-1:0] c_addr;
  logic [CW-1:0] c_wdata;
  logic [23:0]   cycle_count;
  logic [23:0]   result_sum;

  modport slave (
    input  start, a_rdata, b_rdata,
    output busy, done, a_addr, b_addr, c_we, c_addr, c_wdata,
           cycle_count, result_sum
  );

  modport master (
    output start, a_rdata, b_rdata,
    input  busy, done, a_addr, b_addr, c_we, c_addr, c_wdata,
           cycle_count, result_sum
  );
endinterface

// File: rtl/matrix_mult_core.sv
// -----------------------------------------------------------------------------
// matrix_mult_core
// Sequential C = A x B engine for square NxN unsigned matrices. One C element
// is produced every N+2 cycles: N read cycles, one drain cycle collecting the
// last product, and one write cycle.
// Ports:
//   CLOCK_50 : sole clock, rising edge
//   reset    : synchronous, active-low
//   bus      : matrix_mult_core_if.slave (handshake, memory ports, status)
// All outputs are driven straight from registers.
// -----------------------------------------------------------------------------
module matrix_mult_core #(
  parameter int N  = 4,
  parameter int DW = 8,
  parameter int CW = 2*DW + $clog2(N),
  parameter int AW = $clog2(N*N)
) (
  input  logic              CLOCK_50,
  input  logic              reset,
  matrix_mult_core_if.slave bus
);

  localparam int              IW      = (N > 1) ? $clog2(N) : 1;
  localparam logic [IW-1:0]   LAST    = IW'(N - 1);
  localparam logic [23:0]     CNT_MAX = 24'hFFFFFF;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RUN   = 3'd1,
    S_DRAIN = 3'd2,
    S_WRITE = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t          r_state, w_state_nxt;
  logic [IW-1:0]   r_i, r_j, r_k;
  logic [IW-1:0]   w_i_nxt, w_j_nxt, w_k_nxt;
  logic [CW-1:0]   r_acc, w_acc_nxt;
  logic            r_vld;
  logic            w_start_acc;
  logic [2*DW-1:0] w_prod;
  logic [AW-1:0]   r_a_addr, r_b_addr, r_c_addr;
  logic [CW-1:0]   r_c_wdata;
  logic            r_c_we, r_busy, r_done;
  logic [23:0]     r_cycle_count, r_result_sum;

  // Row-major linear address of element (row, col).
  function automatic logic [AW-1:0] f_addr(input logic [IW-1:0] row,
                                           input logic [IW-1:0] col);
    return AW'(row) * AW'(N) + AW'(col);
  endfunction

  assign w_prod = (2*DW)'(bus.a_rdata) * (2*DW)'(bus.b_rdata);

  // Next-state, loop-counter and accumulator logic.
  always_comb begin
    w_state_nxt = r_state;
    w_i_nxt     = r_i;
    w_j_nxt     = r_j;
    w_k_nxt     = r_k;
    w_acc_nxt   = r_acc;
    w_start_acc = 1'b0;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (bus.start) begin
          w_start_acc = 1'b1;
          w_state_nxt = S_RUN;
          w_i_nxt     = '0;
          w_j_nxt     = '0;
          w_k_nxt     = '0;
          w_acc_nxt   = '0;
        end else begin
          w_state_nxt = r_state;
        end
      end
      S_RUN: begin
        // First RUN cycle of an element has no read data in flight yet.
        if (r_vld) begin
          w_acc_nxt = r_acc + CW'(w_prod);
        end else begin
          w_acc_nxt = r_acc;
        end
        if (r_k == LAST) begin
          w_k_nxt     = '0;
          w_state_nxt = S_DRAIN;
        end else begin
          w_k_nxt     = r_k + IW'(1);
        end
      end
      S_DRAIN: begin
        w_acc_nxt   = r_acc + CW'(w_prod);
        w_state_nxt = S_WRITE;
      end
      S_WRITE: begin
        w_acc_nxt = '0;
        if (r_j == LAST) begin
          w_j_nxt = '0;
          if (r_i == LAST) begin
            w_i_nxt = '0;
          end else begin
            w_i_nxt = r_i + IW'(1);
          end
        end else begin
          w_j_nxt = r_j + IW'(1);
        end
        if ((r_i == LAST) && (r_j == LAST)) begin
          w_state_nxt = S_DONE;
        end else begin
          w_state_nxt = S_RUN;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // State, counters and registered outputs, with synchronous active-low reset.
  always_ff @(posedge CLOCK_50) begin
    if (!reset) begin
      r_state       <= S_IDLE;
      r_i           <= '0;
      r_j           <= '0;
      r_k           <= '0;
      r_acc         <= '0;
      r_vld         <= 1'b0;
      r_a_addr      <= '0;
      r_b_addr      <= '0;
      r_c_addr      <= '0;
      r_c_wdata     <= '0;
      r_c_we        <= 1'b0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_cycle_count <= 24'd0;
      r_result_sum  <= 24'd0;
    end else begin
      r_state <= w_state_nxt;
      r_i     <= w_i_nxt;
      r_j     <= w_j_nxt;
      r_k     <= w_k_nxt;
      r_acc   <= w_acc_nxt;
      r_vld   <= (r_state == S_RUN);
      // Addresses are loaded for the upcoming RUN cycle so the memory sees
      // them during that cycle; outside RUN they keep their last value.
      if (w_state_nxt == S_RUN) begin
        r_a_addr <= f_addr(w_i_nxt, w_k_nxt);
        r_b_addr <= f_addr(w_k_nxt, w_j_nxt);
      end else begin
        r_a_addr <= r_a_addr;
        r_b_addr <= r_b_addr;
      end
      // The finished dot product is captured on entry to WRITE.
      r_c_we <= (w_state_nxt == S_WRITE);
      if (w_state_nxt == S_WRITE) begin
        r_c_addr  <= f_addr(r_i, r_j);
        r_c_wdata <= w_acc_nxt;
      end else begin
        r_c_addr  <= r_c_addr;
        r_c_wdata <= r_c_wdata;
      end
      r_busy <= (w_state_nxt == S_RUN) || (w_state_nxt == S_DRAIN) ||
                (w_state_nxt == S_WRITE);
      r_done <= (w_state_nxt == S_DONE);
      if (w_start_acc) begin
        r_cycle_count <= 24'd0;
      end else if (r_busy && (r_cycle_count != CNT_MAX)) begin
        r_cycle_count <= r_cycle_count + 24'd1;
      end else begin
        r_cycle_count <= r_cycle_count;
      end
      if (w_start_acc) begin
        r_result_sum <= 24'd0;
      end else if (r_state == S_WRITE) begin
        r_result_sum <= r_result_sum + 24'(r_acc);
      end else begin
        r_result_sum <= r_result_sum;
      end
    end
  end

  assign bus.busy        = r_busy;
  assign bus.done        = r_done;
  assign bus.a_addr      = r_a_addr;
  assign bus.b_addr      = r_b_addr;
  assign bus.c_we        = r_c_we;
  assign bus.c_addr      = r_c_addr;
  assign bus.c_wdata     = r_c_wdata;
  assign bus.cycle_count = r_cycle_count;
  assign bus.result_sum  = r_result_sum;

endmodule

// File: tb/tb_matrix_mult_core.sv
// -----------------------------------------------------------------------------
// tb_matrix_mult_core
// Self-checking bench for matrix_mult_core (N=4, DW=8). Drives the core through
// its interface, models the A/B memories with one-cycle read latency, captures
// every C write and compares against a nested-loop matrix product.
// Cycle numbering: cycle n after a start is the clock period that ends at the
// n-th rising edge after the edge that accepted the start.
// -----------------------------------------------------------------------------
module tb_matrix_mult_core;
  localparam int N        = 4;
  localparam int DW       = 8;
  localparam int NN       = N * N;
  localparam int BUSY_EXP = NN * (N + 2);

  localparam int K_IDENT = 0;
  localparam int K_RAMP  = 1;
  localparam int K_ONES  = 2;
  localparam int K_FF    = 3;
  localparam int K_TWOS  = 4;
  localparam int K_RAND  = 5;

  logic CLOCK_50 = 1'b0;
  logic reset;
  always #10 CLOCK_50 = ~CLOCK_50;

  matrix_mult_core_if #(.N(N), .DW(DW)) mm_if ();
  matrix_mult_core #(.N(N), .DW(DW)) dut (
    .CLOCK_50 (CLOCK_50),
    .reset    (reset),
    .bus      (mm_if)
  );

  logic [DW-1:0] mem_a [NN];
  logic [DW-1:0] mem_b [NN];

  // Synchronous-read A/B memories.
  always @(posedge CLOCK_50) begin
    mm_if.a_rdata <= mem_a[mm_if.a_addr];
    mm_if.b_rdata <= mem_b[mm_if.b_addr];
  end

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  int     tb_cyc = 0;
  int     t0     = 0;
  int     busy_cnt = 0;
  int     cap_addr [$];
  int     cap_n    [$];
  longint cap_data [$];

  // Free-running edge counter for timestamping.
  always @(posedge CLOCK_50) tb_cyc <= tb_cyc + 1;

  // Capture C writes and busy cycles away from the active edge.
  always @(negedge CLOCK_50) begin
    if (mm_if.c_we === 1'b1) begin
      cap_addr.push_back(int'(mm_if.c_addr));
      cap_data.push_back(longint'(mm_if.c_wdata));
      cap_n.push_back(tb_cyc - t0 + 1);
    end
    if (mm_if.busy === 1'b1) busy_cnt++;
  end

  // Reference model: plain matrix product and its 24-bit wrapped sum.
  longint      exp_c [NN];
  logic [23:0] exp_sum;

  task automatic compute_model();
    longint s;
    s = 0;
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        longint acc;
        acc = 0;
        for (int k = 0; k < N; k++)
          acc += longint'(mem_a[i*N+k]) * longint'(mem_b[k*N+j]);
        exp_c[i*N+j] = acc;
        s += acc;
      end
    end
    exp_sum = 24'(s);
  endtask

  task automatic fill(input int kind, input bit is_b);
    for (int r = 0; r < N; r++) begin
      for (int c = 0; c < N; c++) begin
        logic [DW-1:0] v;
        case (kind)
          K_IDENT: v = (r == c) ? DW'(1) : DW'(0);
          K_RAMP:  v = DW'(r*N + c);
          K_ONES:  v = DW'(1);
          K_FF:    v = DW'(255);
          K_TWOS:  v = DW'(2);
          default: v = DW'($urandom_range(0, 255));
        endcase
        if (is_b) mem_b[r*N+c] = v;
        else      mem_a[r*N+c] = v;
      end
    end
  endtask

  task automatic clear_capture();
    cap_addr.delete();
    cap_n.delete();
    cap_data.delete();
    busy_cnt = 0;
  endtask

  task automatic issue_start();
    @(negedge CLOCK_50);
    mm_if.start = 1'b1;
    @(posedge CLOCK_50);
    #1;
    mm_if.start = 1'b0;
    t0 = tb_cyc;
  endtask

  // One complete run with full checking; optional stray start pulses mid-run.
  task automatic do_run(input string tag, input bit pulse_mid, input bit use_tab,
                        input logic [23:0] tab_sum, input longint tab_c5);
    int n;
    bit seen_done;
    compute_model();
    clear_capture();
    issue_start();
    n = 1;
    seen_done = 1'b0;
    @(negedge CLOCK_50);
    chk({tag, "_busy_rise"}, 64'(mm_if.busy), 64'd1);
    chk({tag, "_cnt_restart"}, 64'(mm_if.cycle_count), 64'd0);
    chk({tag, "_sum_restart"}, 64'(mm_if.result_sum), 64'd0);
    while (n < 500 && !seen_done) begin
      if (mm_if.done === 1'b1) begin
        seen_done = 1'b1;
      end else begin
        mm_if.start = (pulse_mid && (n == 9 || n == 49)) ? 1'b1 : 1'b0;
        @(negedge CLOCK_50);
        n++;
      end
    end
    mm_if.start = 1'b0;
    chk({tag, "_done_seen"}, 64'(seen_done), 64'd1);
    chk({tag, "_done_cycle"}, 64'(n), 64'(BUSY_EXP + 1));
    chk({tag, "_cycle_count"}, 64'(mm_if.cycle_count), 64'(BUSY_EXP));
    chk({tag, "_busy_cycles"}, 64'(busy_cnt), 64'(BUSY_EXP));
    chk({tag, "_sum_model"}, 64'(mm_if.result_sum), 64'(exp_sum));
    chk({tag, "_writes"}, 64'(cap_addr.size()), 64'(NN));
    if (use_tab) begin
      chk({tag, "_sum_table"}, 64'(mm_if.result_sum), 64'(tab_sum));
      if (cap_data.size() > 5) chk({tag, "_c5_table"}, 64'(cap_data[5]), 64'(tab_c5));
      else                     chk({tag, "_c5_present"}, 64'(cap_data.size()), 64'(NN));
    end
    for (int idx = 0; idx < cap_addr.size() && idx < NN; idx++) begin
      chk($sformatf("%s_addr%0d", tag, idx), 64'(cap_addr[idx]), 64'(idx));
      chk($sformatf("%s_when%0d", tag, idx), 64'(cap_n[idx]), 64'((N + 2) * (idx + 1)));
      chk($sformatf("%s_data%0d", tag, idx), 64'(cap_data[idx]), 64'(exp_c[idx]));
    end
    repeat (3) @(negedge CLOCK_50);
    chk({tag, "_done_hold"}, 64'(mm_if.done), 64'd1);
    chk({tag, "_idle_busy"}, 64'(mm_if.busy), 64'd0);
    chk({tag, "_count_hold"}, 64'(mm_if.cycle_count), 64'(BUSY_EXP));
  endtask

  typedef struct {
    int          a_kind;
    int          b_kind;
    bit          pulse;
    logic [23:0] exp_sum;
    longint      exp_c5;
  } vec_t;

  vec_t tbl [5];

  initial begin
    tbl[0] = '{K_IDENT, K_RAMP, 1'b0, 24'd120,     64'd5};
    tbl[1] = '{K_ONES,  K_ONES, 1'b0, 24'd64,      64'd4};
    tbl[2] = '{K_FF,    K_FF,   1'b0, 24'd4161600, 64'd260100};
    tbl[3] = '{K_TWOS,  K_TWOS, 1'b0, 24'd256,     64'd16};
    tbl[4] = '{K_ONES,  K_ONES, 1'b1, 24'd64,      64'd4};

    mm_if.start = 1'b0;
    reset = 1'b0;
    fill(K_ONES, 1'b0);
    fill(K_ONES, 1'b1);
    repeat (3) @(posedge CLOCK_50);
    @(negedge CLOCK_50);
    chk("rst_busy",  64'(mm_if.busy),        64'd0);
    chk("rst_done",  64'(mm_if.done),        64'd0);
    chk("rst_c_we",  64'(mm_if.c_we),        64'd0);
    chk("rst_count", 64'(mm_if.cycle_count), 64'd0);
    chk("rst_sum",   64'(mm_if.result_sum),  64'd0);
    chk("rst_a_addr",64'(mm_if.a_addr),      64'd0);
    chk("rst_b_addr",64'(mm_if.b_addr),      64'd0);
    chk("rst_c_addr",64'(mm_if.c_addr),      64'd0);
    reset = 1'b1;

    for (int t = 0; t < 5; t++) begin
      fill(tbl[t].a_kind, 1'b0);
      fill(tbl[t].b_kind, 1'b1);
      do_run($sformatf("vec%0d", t), tbl[t].pulse, 1'b1, tbl[t].exp_sum, tbl[t].exp_c5);
    end

    // Reset dropped in the middle of a run.
    fill(K_RAMP, 1'b0);
    fill(K_RAMP, 1'b1);
    clear_capture();
    issue_start();
    repeat (20) @(negedge CLOCK_50);
    chk("mid_busy_before", 64'(mm_if.busy), 64'd1);
    chk("mid_writes_before", 64'(cap_addr.size()), 64'd3);
    reset = 1'b0;
    @(negedge CLOCK_50);
    chk("mid_busy",  64'(mm_if.busy),        64'd0);
    chk("mid_done",  64'(mm_if.done),        64'd0);
    chk("mid_c_we",  64'(mm_if.c_we),        64'd0);
    chk("mid_count", 64'(mm_if.cycle_count), 64'd0);
    chk("mid_sum",   64'(mm_if.result_sum),  64'd0);
    chk("mid_a_addr",64'(mm_if.a_addr),      64'd0);
    reset = 1'b1;
    repeat (10) @(negedge CLOCK_50);
    chk("mid_no_write", 64'(cap_addr.size()), 64'd3);
    chk("mid_idle_busy", 64'(mm_if.busy), 64'd0);
    do_run("after_rst", 1'b0, 1'b0, 24'd0, 64'd0);

    // Randomised matrices against the reference model.
    for (int r = 0; r < 4; r++) begin
      fill(K_RAND, 1'b0);
      fill(K_RAND, 1'b1);
      do_run($sformatf("rand%0d", r), 1'b0, 1'b0, 24'd0, 64'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
